// File: rtl/topk_stream_drain_if.sv
// Sample-in / drained-result-out stream bundle for topk_stream_drain.
// slave is the top-k block, master is the producer/consumer side.
interface topk_stream_drain_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  din_valid;
    logic [DATA_WIDTH-1:0] din;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] dout;
    logic                  out_last;

    modport slave (
        input  din_valid, din, out_ready,
        output out_valid, dout, out_last
    );

    modport master (
        output din_valid, din, out_ready,
        input  out_valid, dout, out_last
    );
endinterface

// File: rtl/topk_stream_drain.sv
// Sorted bank of the K largest unsigned samples, drained largest-first on flush.
// Optional macro TOPK_DEDUP_EN: drop samples equal to any held entry.
module topk_stream_drain #(
    parameter int DATA_WIDTH = 32,
    parameter int K          = 4
) (
    input  logic                   clk,
    input  logic                   resetn,
    topk_stream_drain_if.slave     bus,
    input  logic                   flush,
    output logic                   busy,
    output logic [$clog2(K+1)-1:0] count
);
    localparam int CW = $clog2(K+1);

    typedef enum logic {COLLECT, DRAIN} state_t;

    state_t state, state_nx;

    logic [DATA_WIDTH-1:0] top     [K];
    logic [DATA_WIDTH-1:0] ins_arr [K];
    logic [DATA_WIDTH-1:0] sh_arr  [K];
    logic [K-1:0]          keep;
    logic                  dup;
    logic                  full;
    logic                  ins;
    logic                  hs;

    assign full = (count == CW'(K));
    assign hs   = (state == DRAIN) && bus.out_ready;

    assign bus.out_valid = (state == DRAIN);
    assign busy          = (state == DRAIN);
    assign bus.dout      = top[0];
    assign bus.out_last  = (state == DRAIN) && (count == CW'(1));

    // keep[i]: valid entry that stays ahead of din (>= puts din after ties)
    always_comb begin
        keep = '0;
        dup  = 1'b0;
        for (int i = 0; i < K; i++) begin
            keep[i] = (CW'(i) < count) && (top[i] >= bus.din);
            sh_arr[i] = '0;
`ifdef TOPK_DEDUP_EN
            dup = dup | ((CW'(i) < count) && (top[i] == bus.din));
`endif
        end
        ins_arr[0] = keep[0] ? top[0] : bus.din;
        for (int i = 1; i < K; i++) begin
            if (keep[i])
                ins_arr[i] = top[i];
            else if (keep[i-1])
                ins_arr[i] = bus.din;
            else
                ins_arr[i] = top[i-1];
            sh_arr[i-1] = top[i];
        end
    end

    assign ins = (state == COLLECT) && bus.din_valid && !dup &&
                 (!full || (bus.din > top[K-1]));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state <= COLLECT;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            COLLECT:
                if (flush && ((count != '0) || ins))
                    state_nx = DRAIN;
            DRAIN:
                if (hs && bus.out_last)
                    state_nx = COLLECT;
            default:
                state_nx = COLLECT;
        endcase
    end

    // Freed slots above count are always 0, which the insert path relies on
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
            for (int i = 0; i < K; i++)
                top[i] <= '0;
        end else if (ins) begin
            top <= ins_arr;
            if (!full)
                count <= count + CW'(1);
        end else if (hs) begin
            top   <= sh_arr;
            count <= count - CW'(1);
        end
    end
endmodule

// File: tb/tb_topk_stream_drain.sv
// Directed self-checking bench for topk_stream_drain (K=4, DATA_WIDTH=32).
// Also builds with TOPK_DEDUP_EN defined.
module tb_topk_stream_drain;
    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       flush = 1'b0;
    logic       busy;
    logic [2:0] count;

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] exp_a [4];

    topk_stream_drain_if #(.DATA_WIDTH(32)) bus ();

    topk_stream_drain #(.DATA_WIDTH(32), .K(4)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus),
        .flush  (flush),
        .busy   (busy),
        .count  (count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] v);
        bus.din_valid = 1'b1;
        bus.din = v;
        step();
        bus.din_valid = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    // out_ready held high; optional din noise must be ignored in DRAIN
    task automatic drain(input int n, input bit noise);
        for (int j = 0; j < n; j++) begin
            chk($sformatf("valid%0d", j), {31'b0, bus.out_valid}, 1);
            chk($sformatf("busy%0d", j), {31'b0, busy}, 1);
            chk($sformatf("dout%0d", j), bus.dout, exp_a[j]);
            chk($sformatf("last%0d", j), {31'b0, bus.out_last},
                (j == n - 1) ? 32'd1 : 32'd0);
            bus.din_valid = noise;
            bus.din = 32'd100;
            step();
            bus.din_valid = 1'b0;
        end
        chk("end_valid", {31'b0, bus.out_valid}, 0);
        chk("end_busy", {31'b0, busy}, 0);
        chk("end_count", {29'b0, count}, 0);
    endtask

    initial begin
        bus.din_valid = 1'b0;
        bus.din = '0;
        bus.out_ready = 1'b1;
        #12;
        chk("rst_valid", {31'b0, bus.out_valid}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_count", {29'b0, count}, 0);
        chk("rst_dout", bus.dout, 0);
        chk("rst_last", {31'b0, bus.out_last}, 0);
        resetn = 1'b1;
        step();

        push(5); push(9); push(1); push(7); push(3);
        chk("t1_count", {29'b0, count}, 4);
        do_flush();
        exp_a = '{32'd9, 32'd7, 32'd5, 32'd3};
        drain(4, 1'b0);

        push(4); push(4);
`ifdef TOPK_DEDUP_EN
        chk("t2_count", {29'b0, count}, 1);
        do_flush();
        exp_a = '{32'd4, 32'd0, 32'd0, 32'd0};
        drain(1, 1'b0);
`else
        chk("t2_count", {29'b0, count}, 2);
        do_flush();
        exp_a = '{32'd4, 32'd4, 32'd0, 32'd0};
        drain(2, 1'b0);
`endif

        push(7); push(9);
        bus.out_ready = 1'b0;
        do_flush();
        for (int c = 0; c < 3; c++) begin
            chk("t3_hold_valid", {31'b0, bus.out_valid}, 1);
            chk("t3_hold_dout", bus.dout, 9);
            chk("t3_hold_last", {31'b0, bus.out_last}, 0);
            chk("t3_hold_count", {29'b0, count}, 2);
            step();
        end
        bus.out_ready = 1'b1;
        exp_a = '{32'd9, 32'd7, 32'd0, 32'd0};
        drain(2, 1'b0);

        push(2); push(6);
        bus.din_valid = 1'b1;
        bus.din = 32'd8;
        flush = 1'b1;
        step();
        bus.din_valid = 1'b0;
        flush = 1'b0;
        exp_a = '{32'd8, 32'd6, 32'd2, 32'd0};
        drain(3, 1'b1);

        do_flush();
        chk("t5_empty_valid", {31'b0, bus.out_valid}, 0);
        chk("t5_empty_busy", {31'b0, busy}, 0);
        step();
        chk("t5_empty_valid2", {31'b0, bus.out_valid}, 0);
        push(3); push(1);
        bus.out_ready = 1'b0;
        do_flush();
        chk("t5_pre_valid", {31'b0, bus.out_valid}, 1);
        resetn = 1'b0;
        #1;
        chk("t5_rst_valid", {31'b0, bus.out_valid}, 0);
        chk("t5_rst_count", {29'b0, count}, 0);
        chk("t5_rst_dout", bus.dout, 0);
        chk("t5_rst_busy", {31'b0, busy}, 0);
        step();
        resetn = 1'b1;
        bus.out_ready = 1'b1;
        step();

        push(32'hFFFF_FFFF); push(32'h0); push(32'hFFFF_FFFE);
        push(32'h1); push(32'h2);
        push(32'h1);
        chk("t6_count", {29'b0, count}, 4);
        do_flush();
        exp_a = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h2, 32'h1};
        drain(4, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
